// File: rtl/simple_axi_pkg.sv
// Shared AXI4 constants and the state encoding used by the single-beat RAM
// slave. The host-side master imports the same package.
package simple_axi_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI beat sizes (bytes = 1 << size)
    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    // Only incrementing bursts are ever issued by the master
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Slave FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_W_NEED_W  = 3'd1;
    localparam logic [2:0] ST_W_NEED_AW = 3'd2;
    localparam logic [2:0] ST_W_RESP    = 3'd3;
    localparam logic [2:0] ST_R_DATA    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_W_NEED_W  = ST_W_NEED_W,
        S_W_NEED_AW = ST_W_NEED_AW,
        S_W_RESP    = ST_W_RESP,
        S_R_DATA    = ST_R_DATA
    } slave_state_e;

endpackage

// File: rtl/simple_ram_64.sv
// DEPTH x 64-bit single-port RAM: synchronous read, per-byte write enables,
// no reset (contents are undefined at power-up).
module simple_ram_64 #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW_IDX = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [7:0]        we_i,
    input  logic [AW_IDX-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    // Byte-masked write and registered read share the single address port
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/simple_axi_ram_slave.sv
// Single-beat AXI4 slave backed by a 64-bit on-chip RAM. One transaction at a
// time; AW and W may arrive in either order; writes win over a simultaneous read.
module simple_axi_ram_slave
    import simple_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW_IDX    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,
    input  logic [7:0]  s_axi_awlen,
    input  logic [1:0]  s_axi_awburst,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,
    input  logic [7:0]  s_axi_arlen,
    input  logic [1:0]  s_axi_arburst,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arqos,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast
);

    // Window size in bytes; 33 bits so the top of the 32-bit space never wraps
    localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

    // Error classification: a miss outranks any malformed-beat error
    function automatic logic [1:0] calc_resp(input logic       hit,
                                             input logic [7:0] len,
                                             input logic [2:0] size,
                                             input logic       last);
        if (!hit) return RESP_DECERR;
        if (len != 8'd0 || size > SIZE_DWORD || !last) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [1:0]   rst_sync_q;
    logic         rst_n_int;
    slave_state_e state_q;

    logic [31:0]  awaddr_q;
    logic [2:0]   awsize_q;
    logic [7:0]   awlen_q;
    logic [63:0]  wdata_q;
    logic [7:0]   wstrb_q;
    logic         wlast_q;

    logic         bvalid_q;
    logic [1:0]   bresp_q;
    logic         rvalid_q;
    logic [1:0]   rresp_q;
    logic         rd_ok_q;

    logic         aw_hs, w_hs, ar_hs, wr_fire;
    logic [31:0]  wr_addr_d;
    logic [2:0]   wr_size_d;
    logic [7:0]   wr_len_d;
    logic [63:0]  wr_data_d;
    logic [7:0]   wr_strb_d;
    logic         wr_last_d;
    logic [32:0]  wr_off_d, rd_off_d;
    logic [AW_IDX-1:0] wr_idx_d, rd_idx_d, ram_addr_d;
    logic [1:0]   wr_resp_d, rd_resp_d;
    logic [7:0]   ram_we_d;
    logic         ram_re_d;
    logic [63:0]  ram_rdata;

    // Reset asserts asynchronously and releases two clocks after i_rst_n rises
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Ready decode from state; held low while the block is in reset
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        if (rst_n_int) begin
            case (state_q)
                S_IDLE: begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    s_axi_arready = !(s_axi_awvalid | s_axi_wvalid);
                end
                S_W_NEED_W:  s_axi_wready  = 1'b1;
                S_W_NEED_AW: s_axi_awready = 1'b1;
                default: ;
            endcase
        end
    end

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // The write completes on whichever edge delivers the second of AW/W
    assign wr_fire = ((state_q == S_IDLE)      & aw_hs & w_hs)
                   | ((state_q == S_W_NEED_W)  & w_hs)
                   | ((state_q == S_W_NEED_AW) & aw_hs);

    // Pick the live channel or the earlier captured half of the write
    always_comb begin
        wr_addr_d = s_axi_awaddr;
        wr_size_d = s_axi_awsize;
        wr_len_d  = s_axi_awlen;
        wr_data_d = s_axi_wdata;
        wr_strb_d = s_axi_wstrb;
        wr_last_d = s_axi_wlast;
        if (state_q == S_W_NEED_W) begin
            wr_addr_d = awaddr_q;
            wr_size_d = awsize_q;
            wr_len_d  = awlen_q;
        end
        if (state_q == S_W_NEED_AW) begin
            wr_data_d = wdata_q;
            wr_strb_d = wstrb_q;
            wr_last_d = wlast_q;
        end
    end

    // Unsigned offset from BASE: a borrow lands in bit 32 and forces a miss
    assign wr_off_d  = {1'b0, wr_addr_d}    - {1'b0, BASE_ADDR};
    assign rd_off_d  = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
    assign wr_idx_d  = wr_off_d[AW_IDX+2:3];
    assign rd_idx_d  = rd_off_d[AW_IDX+2:3];
    assign wr_resp_d = calc_resp(wr_off_d < SPAN, wr_len_d, wr_size_d, wr_last_d);
    assign rd_resp_d = calc_resp(rd_off_d < SPAN, s_axi_arlen, s_axi_arsize, 1'b1);

    // Errors never touch the RAM; a write and a read never share an edge
    assign ram_we_d   = (wr_fire && wr_resp_d == RESP_OKAY) ? wr_strb_d : 8'h00;
    assign ram_re_d   = ar_hs && (rd_resp_d == RESP_OKAY);
    assign ram_addr_d = wr_fire ? wr_idx_d : rd_idx_d;

    simple_ram_64 #(
        .DEPTH  (DEPTH),
        .AW_IDX (AW_IDX)
    ) u_ram (
        .clk_i   (i_clk),
        .re_i    (ram_re_d),
        .we_i    (ram_we_d),
        .addr_i  (ram_addr_d),
        .wdata_i (wr_data_d),
        .rdata_o (ram_rdata)
    );

    // Transaction FSM with registered response outputs and half-write capture
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= S_IDLE;
            awaddr_q <= '0;
            awsize_q <= '0;
            awlen_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wlast_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rd_ok_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aw_hs && w_hs) begin
                        state_q  <= S_W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_resp_d;
                    end else if (aw_hs) begin
                        state_q  <= S_W_NEED_W;
                        awaddr_q <= s_axi_awaddr;
                        awsize_q <= s_axi_awsize;
                        awlen_q  <= s_axi_awlen;
                    end else if (w_hs) begin
                        state_q  <= S_W_NEED_AW;
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        wlast_q  <= s_axi_wlast;
                    end else if (ar_hs) begin
                        state_q  <= S_R_DATA;
                        rvalid_q <= 1'b1;
                        rresp_q  <= rd_resp_d;
                        rd_ok_q  <= (rd_resp_d == RESP_OKAY);
                    end
                end
                S_W_NEED_W, S_W_NEED_AW: begin
                    if (wr_fire) begin
                        state_q  <= S_W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_resp_d;
                    end
                end
                S_W_RESP: begin
                    if (s_axi_bready) begin
                        state_q  <= S_IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                S_R_DATA: begin
                    if (s_axi_rready) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rvalid_q;
    // Error reads and the post-reset state present all-zero data
    assign s_axi_rdata  = rd_ok_q ? ram_rdata : 64'h0;

    logic unused_sig;
    assign unused_sig = ^{s_axi_awburst, s_axi_awcache, s_axi_awprot, s_axi_awlock,
                          s_axi_awqos, s_axi_arburst, s_axi_arcache, s_axi_arprot,
                          s_axi_arlock, s_axi_arqos, wr_off_d, rd_off_d};

endmodule

// File: tb/tb_simple_axi_ram_slave.sv
// Scoreboard bench for simple_axi_ram_slave: drivers push expected responses,
// a negedge monitor pops and compares them as the DUT presents B and R beats.
module tb_simple_axi_ram_slave;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 1024;
    localparam longint      SPAN  = longint'(DEPTH) * 8;

    logic        i_clk, i_rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awsize;
    logic [7:0]  s_axi_awlen;
    logic [1:0]  s_axi_awburst;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awqos;
    logic        s_axi_wvalid, s_axi_wready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arsize;
    logic [7:0]  s_axi_arlen;
    logic [1:0]  s_axi_arburst;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arqos;
    logic        s_axi_rvalid, s_axi_rready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;

    simple_axi_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awlock(s_axi_awlock), .s_axi_awqos(s_axi_awqos),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arlock(s_axi_arlock), .s_axi_arqos(s_axi_arqos),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct { logic [1:0] resp; logic [63:0] data; } rexp_t;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] mdl [DEPTH];
    logic [1:0]  bq [$];
    rexp_t       rq [$];
    int          b_done = 0;
    int          r_done = 0;
    bit          hold_b = 1'b0;
    bit          hold_r = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules: miss -> DECERR, malformed beat -> SLVERR, else OKAY
    function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input bit last);
        longint a;
        a = longint'({32'h0, addr});
        if (a < longint'({32'h0, BASE}) || a >= longint'({32'h0, BASE}) + SPAN) return 2'b11;
        if (len != 0 || size > 3 || !last) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int ref_idx(input logic [31:0] addr);
        return int'((addr - BASE) / 8) % DEPTH;
    endfunction

    function automatic bit rdy(input int which);
        case (which)
            0:       return s_axi_awready;
            1:       return s_axi_wready;
            2:       return s_axi_arready;
            default: return s_axi_awready && s_axi_wready;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Wait (bounded) for the selected ready; returns just after the handshake edge
    task automatic wait_ready(input int which, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (rdy(which)) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL %s: ready still low after 50 cycles", name); end
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_count(input bit is_r, input int target, input string name);
        int n = 0;
        while ((is_r ? r_done : b_done) < target && n < 300) begin tick(); n++; end
        check(name, 64'((is_r ? r_done : b_done) >= target), 64'd1);
    endtask

    // mode 0: AW+W together, 1: W then AW after gap, 2: AW then W after gap
    task automatic send_write(input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input logic [7:0] len,
                              input logic [2:0] size, input bit last,
                              input int mode, input int gap);
        int tgt;
        logic [1:0] r;
        tgt = b_done + 1;
        r = ref_resp(addr, len, size, last);
        bq.push_back(r);
        if (r == 2'b00)
            for (int b = 0; b < 8; b++)
                if (strb[b]) mdl[ref_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_wdata = data;  s_axi_wstrb = strb; s_axi_wlast = last;
        if (mode == 0) begin
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
            wait_ready(3, "aw_w_hs");
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end else if (mode == 1) begin
            s_axi_wvalid = 1'b1;
            wait_ready(1, "w_first_hs");
            s_axi_wvalid = 1'b0;
            repeat (gap) tick();
            s_axi_awvalid = 1'b1;
            wait_ready(0, "aw_second_hs");
            s_axi_awvalid = 1'b0;
        end else begin
            s_axi_awvalid = 1'b1;
            wait_ready(0, "aw_first_hs");
            s_axi_awvalid = 1'b0;
            repeat (gap) tick();
            s_axi_wvalid = 1'b1;
            wait_ready(1, "w_second_hs");
            s_axi_wvalid = 1'b0;
        end
        wait_count(1'b0, tgt, "b_done");
    endtask

    task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        rexp_t e;
        e.resp = ref_resp(addr, len, size, 1'b1);
        e.data = (e.resp == 2'b00) ? mdl[ref_idx(addr)] : 64'h0;
        rq.push_back(e);
    endtask

    task automatic send_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        int tgt;
        tgt = r_done + 1;
        push_read_exp(addr, len, size);
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arvalid = 1'b1;
        wait_ready(2, "ar_hs");
        s_axi_arvalid = 1'b0;
        wait_count(1'b1, tgt, "r_done");
    endtask

    // Random response backpressure, forced low while a hold is requested
    initial begin
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            s_axi_bready = !hold_b && ($urandom_range(0, 3) != 0);
            s_axi_rready = !hold_r && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each B/R beat as it handshakes and check held responses stay stable
    initial begin
        bit b_hold = 1'b0, r_hold = 1'b0;
        logic [1:0] b_hresp, r_hresp;
        logic [63:0] r_hdata;
        logic [1:0] eb;
        rexp_t er;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                b_hold = 1'b0; r_hold = 1'b0;
            end else begin
                if (b_hold) begin
                    check("b_stable_valid", 64'(s_axi_bvalid), 64'd1);
                    check("b_stable_resp", 64'(s_axi_bresp), 64'(b_hresp));
                end
                if (r_hold) begin
                    check("r_stable_valid", 64'(s_axi_rvalid), 64'd1);
                    check("r_stable_resp", 64'(s_axi_rresp), 64'(r_hresp));
                    check("r_stable_data", s_axi_rdata, r_hdata);
                end
                if (s_axi_bvalid && s_axi_bready) begin
                    tests++;
                    if (bq.size() == 0) begin
                        fails++; $display("FAIL b_unexpected: bresp %h with nothing outstanding", s_axi_bresp);
                    end else begin
                        tests--;
                        eb = bq.pop_front();
                        check("bresp", 64'(s_axi_bresp), 64'(eb));
                    end
                    b_done++;
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    tests++;
                    if (rq.size() == 0) begin
                        fails++; $display("FAIL r_unexpected: rdata %h with nothing outstanding", s_axi_rdata);
                    end else begin
                        tests--;
                        er = rq.pop_front();
                        check("rresp", 64'(s_axi_rresp), 64'(er.resp));
                        check("rdata", s_axi_rdata, er.data);
                        check("rlast", 64'(s_axi_rlast), 64'd1);
                    end
                    r_done++;
                end
                b_hold = s_axi_bvalid && !s_axi_bready; b_hresp = s_axi_bresp;
                r_hold = s_axi_rvalid && !s_axi_rready; r_hresp = s_axi_rresp; r_hdata = s_axi_rdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence
    initial begin
        logic [31:0] a;
        int tb_tgt, tr_tgt;
        i_rst_n = 1'b0;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awsize = 3; s_axi_awlen = 0;
        s_axi_awburst = 2'b01; s_axi_awcache = 0; s_axi_awprot = 0; s_axi_awlock = 0; s_axi_awqos = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 1;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arsize = 3; s_axi_arlen = 0;
        s_axi_arburst = 2'b01; s_axi_arcache = 0; s_axi_arprot = 0; s_axi_arlock = 0; s_axi_arqos = 0;
        repeat (3) tick();
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_rlast",  64'(s_axi_rlast),  64'd0);
        check("rst_bresp",  64'(s_axi_bresp),  64'd0);
        check("rst_rresp",  64'(s_axi_rresp),  64'd0);
        check("rst_rdata",  s_axi_rdata,       64'd0);
        i_rst_n = 1'b1;
        repeat (4) tick();

        // Preload the windows the random phase draws from
        for (int i = 0; i < 32; i++)
            send_write(32'(i * 8), {$urandom, $urandom}, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);
        for (int i = DEPTH - 8; i < DEPTH; i++)
            send_write(32'(i * 8), {$urandom, $urandom}, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);

        // Write then read, byte strobes, split AW/W in both orders
        send_write(32'h10, 64'h1122334455667788, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);
        send_read(32'h10, 8'd0, 3'd3);
        send_write(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);
        send_write(32'h10, 64'h0000000000AB0000, 8'h04, 8'd0, 3'd3, 1'b1, 0, 0);
        send_read(32'h10, 8'd0, 3'd3);
        send_write(32'h18, 64'hCAFEF00DDEADBEEF, 8'hFF, 8'd0, 3'd3, 1'b1, 1, 3);
        send_read(32'h18, 8'd0, 3'd3);
        send_write(32'h20, 64'h0123456789ABCDEF, 8'hF0, 8'd0, 3'd3, 1'b1, 2, 3);
        send_read(32'h20, 8'd0, 3'd3);

        // Decode edges and error priority
        send_read(32'h1FF8, 8'd0, 3'd3);
        send_read(32'h2000, 8'd0, 3'd3);
        send_write(32'h2000, 64'h5555AAAA5555AAAA, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);
        send_read(32'h0, 8'd0, 3'd3);
        send_write(32'h28, 64'h1111111111111111, 8'hFF, 8'd1, 3'd3, 1'b1, 0, 0);
        send_write(32'h28, 64'h2222222222222222, 8'hFF, 8'd0, 3'd3, 1'b0, 2, 1);
        send_write(32'h28, 64'h3333333333333333, 8'hFF, 8'd0, 3'd4, 1'b1, 1, 1);
        send_write(32'h2000, 64'h4444444444444444, 8'hFF, 8'd1, 3'd7, 1'b0, 0, 0);
        send_read(32'h28, 8'd0, 3'd3);
        send_read(32'h30, 8'd2, 3'd3);
        send_read(32'hFFFF_FFF8, 8'd0, 3'd3);
        send_write(32'h30, 64'h7777777777777777, 8'h00, 8'd0, 3'd3, 1'b1, 0, 0);
        send_read(32'h30, 8'd0, 3'd3);

        // Response backpressure: B then R held for several cycles
        hold_b = 1'b1; tick(); tick();
        fork
            send_write(32'h38, 64'h0BADC0DE0BADC0DE, 8'hFF, 8'd0, 3'd3, 1'b1, 0, 0);
            begin repeat (7) tick(); check("b_held_valid", 64'(s_axi_bvalid), 64'd1); hold_b = 1'b0; end
        join
        hold_r = 1'b1; tick(); tick();
        fork
            send_read(32'h38, 8'd0, 3'd3);
            begin repeat (7) tick(); check("r_held_valid", 64'(s_axi_rvalid), 64'd1); hold_r = 1'b0; end
        join

        // AW+W+AR together: write first, read only after the B handshake
        tb_tgt = b_done + 1; tr_tgt = r_done + 1;
        bq.push_back(2'b00);
        mdl[ref_idx(32'h40)] = 64'hA5A5A5A5F0F0F0F0;
        push_read_exp(32'h40, 8'd0, 3'd3);
        s_axi_awaddr = 32'h40; s_axi_awlen = 0; s_axi_awsize = 3;
        s_axi_wdata = 64'hA5A5A5A5F0F0F0F0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1;
        s_axi_araddr = 32'h40; s_axi_arlen = 0; s_axi_arsize = 3;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
        #1;
        check("ar_blocked", 64'(s_axi_arready), 64'd0);
        wait_ready(3, "simul_aw_w_hs");
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        wait_ready(2, "simul_ar_hs");
        s_axi_arvalid = 0;
        check("r_after_b", 64'(b_done >= tb_tgt), 64'd1);
        wait_count(1'b1, tr_tgt, "simul_r_done");

        // Reset while waiting for W: half-write is discarded
        s_axi_awaddr = 32'h48; s_axi_awlen = 0; s_axi_awsize = 3; s_axi_awvalid = 1;
        wait_ready(0, "rst_aw_hs");
        s_axi_awvalid = 0;
        s_axi_wdata = 64'hDEADDEADDEADDEAD; s_axi_wstrb = 8'hFF;
        tick();
        i_rst_n = 1'b0;
        #1;
        check("rstw_bvalid", 64'(s_axi_bvalid), 64'd0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (4) tick();
        send_read(32'h48, 8'd0, 3'd3);
        send_write(32'h50, 64'h600DF00D600DF00D, 8'hFF, 8'd0, 3'd3, 1'b1, 1, 1);
        send_read(32'h50, 8'd0, 3'd3);

        // Reset while a read response is pending
        hold_r = 1'b1; tick(); tick();
        s_axi_araddr = 32'h50; s_axi_arlen = 0; s_axi_arsize = 3; s_axi_arvalid = 1;
        wait_ready(2, "rst_ar_hs");
        s_axi_arvalid = 0;
        check("rstr_pending", 64'(s_axi_rvalid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("rstr_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rstr_rlast",  64'(s_axi_rlast),  64'd0);
        check("rstr_rdata",  s_axi_rdata,       64'd0);
        repeat (3) tick();
        hold_r = 1'b0;
        i_rst_n = 1'b1;
        repeat (4) tick();
        send_read(32'h50, 8'd0, 3'd3);

        // Randomized mix against the reference model
        for (int t = 0; t < 200; t++) begin
            int sel;
            logic [7:0] len;
            logic [2:0] size;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       a = 32'h2000 + 32'($urandom_range(0, 4095)) * 8;
                1:       a = 32'hFFFF_FFF8;
                2, 3:    a = 32'((DEPTH - 8 + $urandom_range(0, 7)) * 8);
                default: a = 32'($urandom_range(0, 31) * 8);
            endcase
            a = a | 32'($urandom_range(0, 7));
            len  = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                send_write(a, {$urandom, $urandom}, 8'($urandom), len, size,
                           ($urandom_range(0, 9) != 0), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                send_read(a, len, size);
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (5) tick();
        check("bq_drained", 64'(bq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
